// File: rtl/sipo_frame_buffer.sv
// Serial-in/parallel-out frame collector.
// Gathers DEPTH signed samples into one frame and presents it as a flat bus.
// Capture of the next frame continues while the current one waits in the
// output register. Partial frames can be closed with flush (zero padded).
// On overrun, the block either stalls upstream or drops samples and flags
// overflow, selected by DROP_ON_FULL.
module sipo_frame_buffer #(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 32,
  parameter int DROP_ON_FULL = 0,
  parameter int LEN_W        = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [DATA_W-1:0]    in_data,
  output logic                        in_ready,
  input  logic                        flush,
  output logic [DATA_W*DEPTH-1:0]     frame_out,
  output logic [LEN_W-1:0]            frame_len,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  output logic                        overflow
);

  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FRAME_W = DATA_W * DEPTH;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     wr_idx;
  logic [FRAME_W-1:0]   fill_q;
  logic [LEN_W-1:0]     pend_len;

  logic                 take;
  logic                 slot_free;
  logic                 close;
  logic                 load;
  logic [LEN_W-1:0]     close_len;
  logic [FRAME_W-1:0]   img;

  // Upstream may push while filling; in drop mode it may always push.
  assign in_ready = !rst && ((state == FILL) || (DROP_ON_FULL != 0));

  // Frame image including this cycle's sample, and close/transfer decisions.
  always_comb begin
    take      = in_valid && in_ready && (state == FILL);
    slot_free = !frame_valid || frame_ready;
    img       = fill_q;
    if (take) begin
      img[int'(wr_idx)*DATA_W +: DATA_W] = in_data;
    end
    close_len = LEN_W'(wr_idx) + LEN_W'(take);
    close     = (state == FILL) &&
                ((take && (wr_idx == IDX_W'(DEPTH - 1))) ||
                 (flush && ((wr_idx != '0) || take)));
    load      = slot_free && (close || (state == FULL));
  end

  // Fill FSM, output register and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      wr_idx      <= '0;
      fill_q      <= '0;
      pend_len    <= '0;
      frame_out   <= '0;
      frame_len   <= '0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (load) begin
        // Transfer: a held frame in FULL, otherwise the frame closing now.
        frame_out   <= (state == FULL) ? fill_q : img;
        frame_len   <= (state == FULL) ? pend_len : close_len;
        frame_valid <= 1'b1;
        fill_q      <= '0;
        wr_idx      <= '0;
        state       <= FILL;
      end else begin
        if (frame_valid && frame_ready) begin
          frame_valid <= 1'b0;
        end
        if (state == FILL) begin
          fill_q <= img;
          if (close) begin
            state    <= FULL;
            pend_len <= close_len;
          end else if (take) begin
            wr_idx <= wr_idx + 1'b1;
          end
        end
      end
      if ((state == FULL) && in_valid && (DROP_ON_FULL != 0)) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_buffer.sv
// Bench for sipo_frame_buffer: one backpressure instance and one drop-mode
// instance share the same stimulus, each compared every cycle against a
// frame-level reference model.
module tb_sipo_frame_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam int LEN_W  = 6;
  localparam int FW     = DATA_W * DEPTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     flush;
  logic                     frame_ready;

  logic             rdy0, rdy1, fv0, fv1, ovf0, ovf1;
  logic [FW-1:0]    fo0, fo1;
  logic [LEN_W-1:0] fl0, fl1;

  sipo_frame_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_ON_FULL(0)) dut_bp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .flush(flush), .frame_out(fo0), .frame_len(fl0),
    .frame_valid(fv0), .frame_ready(frame_ready), .overflow(ovf0)
  );

  sipo_frame_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_ON_FULL(1)) dut_drop (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .flush(flush), .frame_out(fo1), .frame_len(fl1),
    .frame_valid(fv1), .frame_ready(frame_ready), .overflow(ovf1)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state, index 0 = backpressure, 1 = drop mode.
  int          mcnt   [2];
  logic [15:0] mfill  [2][DEPTH];
  bit          mpend  [2];
  int          mplen  [2];
  logic [15:0] mpbuf  [2][DEPTH];
  logic [15:0] mout   [2][DEPTH];
  int          mlen   [2];
  bit          mvalid [2];
  bit          movf   [2];

  bit last_rdy0;
  int n;
  logic [15:0] fvals [5];

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] flat(input int id);
    logic [FW-1:0] v;
    v = '0;
    for (int k = 0; k < DEPTH; k++) v[k*DATA_W +: DATA_W] = mout[id][k];
    return v;
  endfunction

  function automatic bit exp_ready(input int id);
    return !rst && (!mpend[id] || id == 1);
  endfunction

  task automatic model_step(input int id);
    bit sf;
    if (rst) begin
      mcnt[id] = 0; mpend[id] = 0; mplen[id] = 0; mlen[id] = 0;
      mvalid[id] = 0; movf[id] = 0;
      for (int k = 0; k < DEPTH; k++) mout[id][k] = '0;
      return;
    end
    sf = !mvalid[id] || frame_ready;
    if (mpend[id]) begin
      if (in_valid && id == 1) movf[id] = 1;
      if (sf) begin
        for (int k = 0; k < DEPTH; k++) mout[id][k] = mpbuf[id][k];
        mlen[id] = mplen[id]; mvalid[id] = 1; mpend[id] = 0;
      end
      return;
    end
    if (mvalid[id] && frame_ready) mvalid[id] = 0;
    if (in_valid) begin
      mfill[id][mcnt[id]] = in_data;
      mcnt[id]++;
    end
    if (mcnt[id] == DEPTH || (flush && mcnt[id] > 0)) begin
      if (sf) begin
        for (int k = 0; k < DEPTH; k++) mout[id][k] = (k < mcnt[id]) ? mfill[id][k] : 16'h0;
        mlen[id] = mcnt[id]; mvalid[id] = 1;
      end else begin
        for (int k = 0; k < DEPTH; k++) mpbuf[id][k] = (k < mcnt[id]) ? mfill[id][k] : 16'h0;
        mplen[id] = mcnt[id]; mpend[id] = 1;
      end
      mcnt[id] = 0;
    end
  endtask

  task automatic cycle();
    #1;
    chk("in_ready_bp", FW'(rdy0), FW'(exp_ready(0)));
    chk("in_ready_drop", FW'(rdy1), FW'(exp_ready(1)));
    last_rdy0 = exp_ready(0);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    chk("frame_valid_bp", FW'(fv0), FW'(mvalid[0]));
    chk("frame_len_bp", FW'(fl0), FW'(mlen[0]));
    chk("frame_out_bp", fo0, flat(0));
    chk("overflow_bp", FW'(ovf0), FW'(movf[0]));
    chk("frame_valid_drop", FW'(fv1), FW'(mvalid[1]));
    chk("frame_len_drop", FW'(fl1), FW'(mlen[1]));
    chk("frame_out_drop", fo1, flat(1));
    chk("overflow_drop", FW'(ovf1), FW'(movf[1]));
  endtask

  task automatic stream(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      in_valid = 1'b1;
      in_data  = 16'(-n);
      cycle();
      if (last_rdy0) n++;
    end
  endtask

  task automatic rand_samples(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      cycle();
    end
  endtask

  task automatic idle(input int ncyc);
    in_valid = 1'b0;
    flush    = 1'b0;
    for (int c = 0; c < ncyc; c++) cycle();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; frame_ready = 1'b0;
    for (int id = 0; id < 2; id++) begin
      for (int k = 0; k < DEPTH; k++) begin
        mfill[id][k] = '0; mpbuf[id][k] = '0; mout[id][k] = '0;
      end
    end
    // Reset state
    cycle();
    cycle();
    rst = 1'b0;

    // Full frame at full rate
    frame_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      cycle();
    end
    idle(2);

    // Backpressure versus drop on overrun
    frame_ready = 1'b0;
    n = 1;
    stream(75);
    frame_ready = 1'b1;
    stream(1);
    frame_ready = 1'b0;
    stream(5);
    frame_ready = 1'b1;
    stream(40);
    idle(3);

    // Reset mid-operation with a frame pending
    frame_ready = 1'b0;
    rand_samples(42);
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    frame_ready = 1'b1;
    rand_samples(DEPTH);
    idle(2);

    // Flush of a partial frame, then flush with empty fill
    fvals[0] = 16'h7FFF; fvals[1] = 16'h8000; fvals[2] = 16'h0001;
    fvals[3] = 16'h0002; fvals[4] = 16'h0003;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = fvals[i];
      flush    = (i == 4);
      cycle();
    end
    idle(2);
    flush = 1'b1;
    cycle();
    idle(2);

    // Consumer accepts on the same cycle the next frame closes
    frame_ready = 1'b0;
    rand_samples(DEPTH);
    rand_samples(DEPTH - 1);
    frame_ready = 1'b1;
    rand_samples(1);
    idle(2);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_data     = 16'($urandom);
      flush       = ($urandom_range(0, 15) == 0);
      frame_ready = ($urandom_range(0, 1) == 1);
      rst         = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;
    frame_ready = 1'b1;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_frame_buffer.md
Name: sipo_frame_buffer

Overview:
- Parametrised serial-in/parallel-out frame collector for the THDi datapath.
- Gathers DEPTH signed samples from the ADC/sample stream into one frame and presents it as a flat parallel bus to the FFT/harmonic stage.
- Double-buffered: capture of frame N+1 continues while frame N is held for the consumer.
- Adds valid/ready handshakes, partial-frame flush with zero padding, and a selectable backpressure or drop policy on overrun.

Parameters:
- DATA_W, 16, sample width in bits (two's complement).
- DEPTH, 32, samples per frame (≥2).
- DROP_ON_FULL, 0, 0 = backpressure upstream when both buffers are full; 1 = never stall, discard samples and flag overflow.
- LEN_W, $clog2(DEPTH+1), width of frame_len.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data carries a sample this cycle.
- in_data  in  DATA_W  signed sample.
- in_ready  out  1  block accepts a sample this cycle.
- flush  in  1  single-cycle pulse: close the current partial frame.
- frame_out  out  DATA_W*DEPTH  sample k at frame_out[k*DATA_W +: DATA_W]; k=0 is the oldest sample.
- frame_len  out  LEN_W  number of real samples in frame_out (1..DEPTH).
- frame_valid  out  1  frame_out/frame_len are valid and held stable.
- frame_ready  in  1  consumer takes the frame when frame_valid && frame_ready.
- overflow  out  1  sticky flag, set when a sample is dropped; cleared only by rst.

Behaviour:
- Storage:
  - Fill buffer: DEPTH x DATA_W, write index wr_idx in 0..DEPTH-1.
  - Output register: frame_out and frame_len.
- Accept: a sample is accepted when in_valid && in_ready. It is written to fill[wr_idx], then wr_idx increments.
- Fill FSM:
  - FILL: in_ready=1.
    - Accepting the sample at wr_idx==DEPTH-1 closes the frame with len=DEPTH.
    - A flush with wr_idx>0 closes the frame with len=wr_idx. If a sample is accepted in the same cycle, it is included first, so len=wr_idx+1.
    - A flush with wr_idx==0 and no sample accepted is ignored.
  - Close handling: if the output slot is free, the frame transfers to the output register at the closing edge, and the fill buffer plus wr_idx clear to 0. Otherwise the FSM goes to FULL holding the frame and len.
  - The output slot is free when frame_valid==0, or frame_valid && frame_ready in the same cycle.
  - FULL:
    - in_ready = DROP_ON_FULL.
    - In drop mode, an in_valid sample is discarded and overflow is set.
    - flush is ignored.
    - When the output slot frees, transfer, clear, return to FILL. No sample is accepted on the transfer cycle.
- Zero padding: unwritten positions (k ≥ frame_len) read as 0, because the fill buffer clears on every transfer.
- Output handshake:
  - frame_valid rises on the clock edge that loads the output register.
  - Latency: the frame is visible 1 cycle after the closing sample or flush.
  - frame_valid falls after the accepting edge unless a new frame loads on the same edge, in which case it stays 1 with the new contents.
  - frame_out and frame_len do not change while frame_valid && !frame_ready.
- Throughput: with frame_ready held high, the stream runs at 1 sample/cycle indefinitely with no stall and no dropped sample.
- Arithmetic: samples are stored bit-exact. No sign extension or saturation.
- Reset (any cycle, including mid-frame or FULL):
  - wr_idx=0, fill buffer=0, FSM=FILL.
  - frame_out=0, frame_len=0, frame_valid=0, overflow=0.
  - in_ready=0 while rst is high. Any partial or pending frame is discarded.

Test Plan:
- Full frame: DEPTH=32, frame_ready=1, feed samples 0..31 on consecutive cycles → frame_valid for 1 cycle the cycle after sample 31; frame_out[k]=k; frame_len=32; in_ready stays 1.
- Backpressure: DROP_ON_FULL=0, frame_ready=0, stream samples -1,-2,... → frame 1 held stable; fill reaches 32 more samples, then in_ready=0 holding sample -65. Raise frame_ready for 1 cycle → frame 2 loads with values -33..-64, and sample -65 is accepted on the cycle after the transfer.
- Drop mode: same stimulus with DROP_ON_FULL=1 → in_ready stays 1; samples from -65 on are discarded while FULL; overflow=1 and stays 1 after the backlog clears.
- Flush: feed 5 samples 0x7FFF, 0x8000, 1, 2, 3 with flush asserted alongside the 5th → frame_len=5; frame_out[0..4]=those values; frame_out[5..31]=0. A further flush with empty fill produces no frame.
- Reset mid-operation: assert rst for 1 cycle after 10 samples with a frame pending → all outputs 0 next cycle. The next 32 samples form a clean frame starting at index 0.
- Simultaneous handoff: consumer asserts frame_ready on the same cycle the next frame closes → frame_valid stays 1, contents switch to the new frame, no cycle is lost.
